// File: rtl/ad400x_multi_deserializer_if.sv
// ad400x_multi_deserializer_if
//   Pin and data bundle of the multi-channel AD400x reader.
//   master: the deserializer (drives converter pins and the published data).
//   slave : board/consumer side (drives adc_sdo, observes everything else).
//   Signals:
//     adc_sdo           [N_CH]         serial data from each converter, MSB first
//     cnvst             1              conversion start to all converters
//     sck               1              shared serial clock
//     sdi               1              held 1 (3-wire CS mode)
//     adc_spi_clk_count [CNT_W]        frame phase counter
//     adc_data          [N_CH*DATA_W]  channel c at [c*DATA_W +: DATA_W]
//     data_valid        1              one-cycle strobe, adc_data updated
//     frame_count       [32]           frames published since reset
interface ad400x_multi_deserializer_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CNT_W  = 6
);
  logic [N_CH-1:0]        adc_sdo;
  logic                   cnvst;
  logic                   sck;
  logic                   sdi;
  logic [CNT_W-1:0]       adc_spi_clk_count;
  logic [N_CH*DATA_W-1:0] adc_data;
  logic                   data_valid;
  logic [31:0]            frame_count;

  modport master (
    input  adc_sdo,
    output cnvst, sck, sdi, adc_spi_clk_count, adc_data, data_valid, frame_count
  );

  modport slave (
    output adc_sdo,
    input  cnvst, sck, sdi, adc_spi_clk_count, adc_data, data_valid, frame_count
  );
endinterface

// File: rtl/ad400x_multi_deserializer.sv
// ad400x_multi_deserializer
//   Drives a shared CNV/SCK pair to N_CH AD400x converters in 3-wire CS mode, runs a
//   fixed PERIOD_CYC frame (conversion, quiet, readout, publish, wait) and deserialises
//   all SDO lines in parallel. Each frame publishes one word per channel with a
//   single-cycle data_valid strobe.
//   Ports:
//     adc_spi_clk  in   sole clock, rising edge
//     rst          in   asynchronous, active-high reset
//     enable       in   run frames while high; a running frame always completes
//     test_mode    in   only with ADC_TEST_PATTERN_EN: publish a channel/frame pattern
//     bus          ad400x_multi_deserializer_if.master (pins and published data)
//   Optional feature macro: ADC_TEST_PATTERN_EN.
module ad400x_multi_deserializer #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned CONV_CYC   = 24,
  parameter int unsigned QUIET_CYC  = 1,
  parameter int unsigned PERIOD_CYC = 64
) (
  input  logic adc_spi_clk,
  input  logic rst,
  input  logic enable,
`ifdef ADC_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  ad400x_multi_deserializer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
  localparam int unsigned R0    = CONV_CYC + QUIET_CYC;
  localparam int unsigned PUB   = R0 + 2 * DATA_W;

  localparam logic [CNT_W-1:0] PhQuiet = CNT_W'(CONV_CYC);
  localparam logic [CNT_W-1:0] PhRead  = CNT_W'(R0);
  localparam logic [CNT_W-1:0] PhPub   = CNT_W'(PUB);
  localparam logic [CNT_W-1:0] PhLast  = CNT_W'(PERIOD_CYC - 1);

  if (PERIOD_CYC < PUB + 1 || N_CH < 1 || N_CH > 32 || CONV_CYC < 1 ||
      !(DATA_W == 16 || DATA_W == 18 || DATA_W == 20)) begin : g_param_err
    $fatal(1, "ad400x_multi_deserializer: illegal parameter set");
  end

  typedef enum logic [2:0] {StIdle, StConv, StQuiet, StRead, StPublish, StWait} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       phase_q, phase_d;
  logic                   cnvst_q, sck_q, data_valid_q;
  logic [N_CH*DATA_W-1:0] shift_q, shift_d, pub_word, adc_data_q;
  logic [31:0]            frame_count_q;
  logic                   sck_d, sample, publish;

  // Running states are a pure function of the frame phase.
  function automatic state_e phase_state(input logic [CNT_W-1:0] p);
    if (p < PhQuiet)     return StConv;
    else if (p < PhRead) return StQuiet;
    else if (p < PhPub)  return StRead;
    else if (p == PhPub) return StPublish;
    else                 return StWait;
  endfunction

  always_ff @(posedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (state_q == StIdle) begin
      if (enable) begin
        state_d = StConv;
        phase_d = '0;
      end
    end else if (phase_q == PhLast) begin
      // enable is only looked at on the frame wrap, so frames never end early.
      phase_d = '0;
      state_d = enable ? StConv : StIdle;
    end else begin
      phase_d = phase_q + 1'b1;
      state_d = phase_state(phase_d);
    end
  end

  // Parity of the read index k = phase - R0 only needs the phase LSBs.
  assign sck_d   = (state_d == StRead) && (phase_d[0] ^ PhRead[0]);
  assign sample  = (state_q == StRead) && (phase_q[0] ^ PhRead[0]);
  assign publish = (state_d == StPublish);

  always_comb begin
    shift_d = shift_q;
    if (sample) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        shift_d[c*DATA_W +: DATA_W] = {shift_q[c*DATA_W +: DATA_W-1], bus.adc_sdo[c]};
      end
    end
  end

  // The last bit lands on the same edge that enters PUBLISH, so publish from shift_d.
  always_comb begin
    pub_word = shift_d;
`ifdef ADC_TEST_PATTERN_EN
    if (test_mode) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        pub_word[c*DATA_W +: DATA_W] = {8'(c), frame_count_q[DATA_W-9:0]};
      end
    end
`endif
  end

  always_ff @(posedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      cnvst_q       <= 1'b0;
      sck_q         <= 1'b0;
      data_valid_q  <= 1'b0;
      shift_q       <= '0;
      adc_data_q    <= '0;
      frame_count_q <= '0;
    end else begin
      cnvst_q      <= (state_d == StConv);
      sck_q        <= sck_d;
      data_valid_q <= publish;
      shift_q      <= shift_d;
      if (publish) begin
        adc_data_q    <= pub_word;
        frame_count_q <= frame_count_q + 32'd1;
      end
    end
  end

  assign bus.cnvst             = cnvst_q;
  assign bus.sck               = sck_q;
  assign bus.sdi               = 1'b1;
  assign bus.adc_spi_clk_count = phase_q;
  assign bus.adc_data          = adc_data_q;
  assign bus.data_valid        = data_valid_q;
  assign bus.frame_count       = frame_count_q;

endmodule

// File: tb/tb_ad400x_multi_deserializer.sv
module tb_ad400x_multi_deserializer;
  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 18;

  logic clk = 1'b0;
  logic rst;
  logic enable;
`ifdef ADC_TEST_PATTERN_EN
  logic test_mode;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] words [NCH];

  ad400x_multi_deserializer_if #(.N_CH(NCH), .DATA_W(DW), .CNT_W(6)) bus ();

  ad400x_multi_deserializer #(.N_CH(NCH), .DATA_W(DW)) dut (
    .adc_spi_clk (clk),
    .rst         (rst),
    .enable      (enable),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Converter model: MSB presented after CNV, next bit after each completed SCK high.
  initial begin
    int  idx;
    bit  prev_sck;
    idx = 0;
    prev_sck = 1'b0;
    bus.adc_sdo = '0;
    forever begin
      @(negedge clk);
      if (bus.cnvst) idx = 0;
      else if (prev_sck) idx++;
      prev_sck = bus.sck;
      for (int c = 0; c < int'(NCH); c++) begin
        bus.adc_sdo[c] = (idx < int'(DW)) ? words[c][DW-1-idx] : 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_dv(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.data_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_phase(input logic [5:0] ph, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 200) begin
      if (bus.adc_spi_clk_count == ph) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.cnvst !== 1'b0) begin bad++; $display("FAIL reset_cnvst got=%b exp=0", bus.cnvst); end
    total++; if (bus.sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.sck); end
    total++; if (bus.sdi !== 1'b1) begin bad++; $display("FAIL reset_sdi got=%b exp=1", bus.sdi); end
    total++;
    if (bus.adc_spi_clk_count !== 6'd0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", bus.adc_spi_clk_count);
    end
    total++;
    if (bus.adc_data !== 36'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", bus.adc_data);
    end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", bus.data_valid); end
    total++;
    if (bus.frame_count !== 32'd0) begin
      bad++; $display("FAIL reset_fc got=%0d exp=0", bus.frame_count);
    end
  endtask

  task automatic test_first_frame();
    int cyc;
    bit ok;
    words[0] = 18'h2A5A5;
    words[1] = 18'h15A5A;
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cnvst !== 1'b1 || bus.adc_spi_clk_count !== 6'd0) begin
      bad++; $display("FAIL first_cnvst_rise got cnvst=%b ph=%0d exp cnvst=1 ph=0",
                      bus.cnvst, bus.adc_spi_clk_count);
    end
    wait_dv(100, cyc, ok);
    total++;
    if (!ok || cyc != 61) begin
      bad++; $display("FAIL first_latency got=%0d ok=%b exp=61", cyc, ok);
    end
    total++;
    if (bus.adc_data !== {18'h15A5A, 18'h2A5A5}) begin
      bad++; $display("FAIL first_data got=%h exp=%h", bus.adc_data, {18'h15A5A, 18'h2A5A5});
    end
    total++;
    if (bus.frame_count !== 32'd1) begin
      bad++; $display("FAIL first_fc got=%0d exp=1", bus.frame_count);
    end
    total++;
    if (bus.adc_spi_clk_count !== 6'd61) begin
      bad++; $display("FAIL first_dv_phase got=%0d exp=61", bus.adc_spi_clk_count);
    end
    @(negedge clk);
    total++;
    if (bus.data_valid !== 1'b0 || bus.adc_data !== {18'h15A5A, 18'h2A5A5}) begin
      bad++; $display("FAIL first_strobe_width got dv=%b data=%h exp dv=0 data held",
                      bus.data_valid, bus.adc_data);
    end
  endtask

  task automatic test_continuous();
    int cnv_cnt [10];
    int rise    [10];
    int dv_cnt  [10];
    int dv_ph   [10];
    bit prev;
    int f;
    for (int i = 0; i < 10; i++) begin
      cnv_cnt[i] = 0; rise[i] = 0; dv_cnt[i] = 0; dv_ph[i] = -1;
    end
    prev = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 640; j++) begin
      @(negedge clk);
      f = j / 64;
      if (bus.cnvst === 1'b1) cnv_cnt[f]++;
      if (bus.sck === 1'b1 && !prev) rise[f]++;
      prev = bus.sck;
      if (bus.data_valid === 1'b1) begin
        dv_cnt[f]++;
        dv_ph[f] = j % 64;
      end
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (cnv_cnt[i] != 24) begin
        bad++; $display("FAIL cont_cnvst_len frame=%0d got=%0d exp=24", i, cnv_cnt[i]);
      end
      total++;
      if (rise[i] != 18) begin
        bad++; $display("FAIL cont_sck_rises frame=%0d got=%0d exp=18", i, rise[i]);
      end
      total++;
      if (dv_cnt[i] != 1 || dv_ph[i] != 61) begin
        bad++; $display("FAIL cont_dv frame=%0d got n=%0d ph=%0d exp n=1 ph=61",
                        i, dv_cnt[i], dv_ph[i]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.frame_count !== 32'd10) begin
      bad++; $display("FAIL cont_fc got=%0d exp=10", bus.frame_count);
    end
    total++;
    if (bus.cnvst !== 1'b1 || bus.adc_spi_clk_count !== 6'd0) begin
      bad++; $display("FAIL cont_wrap got cnvst=%b ph=%0d exp cnvst=1 ph=0",
                      bus.cnvst, bus.adc_spi_clk_count);
    end
  endtask

  task automatic test_enable_drop();
    int cyc;
    bit ok;
    bit saw_cnv;
    bit saw_ph;
    bit saw_dv;
    wait_phase(6'd30, ok);
    enable = 1'b0;
    wait_dv(100, cyc, ok);
    total++;
    if (!ok || cyc != 31 || bus.adc_spi_clk_count !== 6'd61) begin
      bad++; $display("FAIL drop_strobe got cyc=%0d ok=%b ph=%0d exp cyc=31 ph=61",
                      cyc, ok, bus.adc_spi_clk_count);
    end
    total++;
    if (bus.frame_count !== 32'd11) begin
      bad++; $display("FAIL drop_fc got=%0d exp=11", bus.frame_count);
    end
    repeat (3) @(negedge clk);
    saw_cnv = 1'b0; saw_ph = 1'b0; saw_dv = 1'b0;
    for (int j = 0; j < 80; j++) begin
      if (bus.cnvst !== 1'b0) saw_cnv = 1'b1;
      if (bus.adc_spi_clk_count !== 6'd0) saw_ph = 1'b1;
      if (bus.data_valid !== 1'b0) saw_dv = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_cnv) begin bad++; $display("FAIL drop_idle_cnvst got=1 exp=0"); end
    total++; if (saw_ph) begin bad++; $display("FAIL drop_idle_phase got=nonzero exp=0"); end
    total++; if (saw_dv) begin bad++; $display("FAIL drop_idle_dv got=1 exp=0"); end
  endtask

  task automatic test_rst_mid();
    int cyc;
    bit ok;
    bit saw_dv;
    enable = 1'b1;
    @(negedge clk);
    wait_phase(6'd40, ok);
    total++;
    if (!ok || bus.sck !== 1'b1) begin
      bad++; $display("FAIL rst_pre got ok=%b sck=%b exp ok=1 sck=1", ok, bus.sck);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.cnvst !== 1'b0 || bus.sck !== 1'b0 || bus.adc_spi_clk_count !== 6'd0 ||
        bus.data_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async_pins got cnvst=%b sck=%b ph=%0d dv=%b exp all 0",
                      bus.cnvst, bus.sck, bus.adc_spi_clk_count, bus.data_valid);
    end
    total++;
    if (bus.adc_data !== 36'd0 || bus.frame_count !== 32'd0) begin
      bad++; $display("FAIL rst_async_data got data=%h fc=%0d exp 0 0",
                      bus.adc_data, bus.frame_count);
    end
    saw_dv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.data_valid !== 1'b0) saw_dv = 1'b1;
    end
    total++; if (saw_dv) begin bad++; $display("FAIL rst_no_strobe got=1 exp=0"); end
    rst = 1'b0;
    wait_dv(100, cyc, ok);
    total++;
    if (!ok || cyc != 62) begin
      bad++; $display("FAIL rst_fresh_latency got=%0d ok=%b exp=62", cyc, ok);
    end
    total++;
    if (bus.frame_count !== 32'd1 || bus.adc_data !== {18'h15A5A, 18'h2A5A5}) begin
      bad++; $display("FAIL rst_fresh_frame got fc=%0d data=%h exp fc=1 data=%h",
                      bus.frame_count, bus.adc_data, {18'h15A5A, 18'h2A5A5});
    end
  endtask

  task automatic test_sign();
    int cyc;
    bit ok;
    words[0] = 18'h20000;
    words[1] = 18'h1FFFF;
    wait_dv(100, cyc, ok);
    total++;
    if (!ok || cyc != 64 || bus.adc_data !== {18'h1FFFF, 18'h20000}) begin
      bad++; $display("FAIL sign_a got cyc=%0d data=%h exp cyc=64 data=%h",
                      cyc, bus.adc_data, {18'h1FFFF, 18'h20000});
    end
    words[0] = 18'h1FFFF;
    words[1] = 18'h20000;
    wait_dv(100, cyc, ok);
    total++;
    if (!ok || bus.adc_data !== {18'h20000, 18'h1FFFF} || bus.frame_count !== 32'd3) begin
      bad++; $display("FAIL sign_b got data=%h fc=%0d exp data=%h fc=3",
                      bus.adc_data, bus.frame_count, {18'h20000, 18'h1FFFF});
    end
  endtask

`ifdef ADC_TEST_PATTERN_EN
  task automatic test_pattern();
    int cyc;
    bit ok;
    rst = 1'b1;
    test_mode = 1'b1;
    words[0] = 18'h3FFFF;
    words[1] = 18'h2AAAA;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) wait_dv(100, cyc, ok);
    total++;
    if (!ok || bus.adc_data !== {18'h00402, 18'h00002} || bus.frame_count !== 32'd3) begin
      bad++; $display("FAIL pattern got data=%h fc=%0d exp data=%h fc=3",
                      bus.adc_data, bus.frame_count, {18'h00402, 18'h00002});
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    words[0] = '0;
    words[1] = '0;
`ifdef ADC_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    test_reset();
    test_first_frame();
    test_continuous();
    test_enable_drop();
    test_rst_mid();
    test_sign();
`ifdef ADC_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
